// File: rtl/s4ga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : s4ga_pkg                                                          |
// | Brief  : Shared s4ga constants, LUT-record geometry helpers, FSM states.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package s4ga_pkg;

    typedef enum logic [0:0] {
        RST_SEQ = 1'b0,
        STREAM  = 1'b1
    } state_t;

    localparam int SEG_BITS = 4;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int calc_n_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_idx_segs(input int n);
        return ceil_div(calc_n_w(n), SEG_BITS);
    endfunction

    function automatic int calc_mask_segs(input int k);
        return ceil_div(1 << k, SEG_BITS);
    endfunction

    // Segments per LUT record: K input-index fields followed by the truth-table mask.
    function automatic int calc_ll(input int n, input int k);
        return k * calc_idx_segs(n) + calc_mask_segs(k);
    endfunction

    localparam int N_W       = calc_n_w(71);
    localparam int IDX_SEGS  = calc_idx_segs(71);
    localparam int MASK_SEGS = calc_mask_segs(5);
    localparam int LL        = calc_ll(71, 5);

endpackage
`default_nettype wire

// File: rtl/s4ga_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : s4ga_byte_fifo                                                    |
// | Brief  : Power-of-two byte FIFO with flush and next-cycle full flag.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module s4ga_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full_next
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("s4ga_byte_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_AW:0]   w_count_next;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !i_flush && (r_count != c_DEPTH);
    assign w_pop   = i_pop  && !i_flush && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    assign o_full_next = (w_count_next == c_DEPTH);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/s4ga_cfg_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : s4ga_cfg_streamer                                                 |
// | Brief  : Byte-to-nibble config feeder for the s4ga LUT core, with core     |
// |          reset sequencing and LUT/frame boundary tracking.                 |
// |          Optional macro S4GA_CFG_STATS_EN enables the underrun counter.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module s4ga_cfg_streamer
    import s4ga_pkg::*;
#(
    parameter int N          = 71,
    parameter int K          = 5,
    parameter int SI_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_STEPS  = N + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SI_W-1:0] si,
    output logic            step,
    output logic            core_rst,
    output logic            lut_done,
    output logic            frame_done,
    output logic [15:0]     underrun_cnt
);

    localparam int c_LL    = calc_ll(N, K);
    localparam int c_SEG_W = $clog2(c_LL);
    localparam int c_LUT_W = calc_n_w(N);
    localparam int c_RST_W = $clog2(RST_STEPS + 1);

    localparam logic [c_SEG_W-1:0] c_SEG_LAST = c_SEG_W'(c_LL - 1);
    localparam logic [c_SEG_W-1:0] c_SEG_ONE  = c_SEG_W'(1);
    localparam logic [c_LUT_W-1:0] c_LUT_LAST = c_LUT_W'(N - 1);
    localparam logic [c_LUT_W-1:0] c_LUT_ONE  = c_LUT_W'(1);
    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(RST_STEPS - 1);
    localparam logic [c_RST_W-1:0] c_RST_ONE  = c_RST_W'(1);

    generate
        if (SI_W != 4) begin : g_bad_si_w
            $error("s4ga_cfg_streamer: SI_W must be 4");
        end
        if (RST_STEPS <= N) begin : g_bad_rst_steps
            $error("s4ga_cfg_streamer: RST_STEPS must exceed N");
        end
    endgenerate

    state_t              r_state;
    logic [c_RST_W-1:0]  r_rst_cnt;
    logic                r_phase;
    logic [c_SEG_W-1:0]  r_seg_cnt;
    logic [c_LUT_W-1:0]  r_lut_cnt;
    logic [SI_W-1:0]     r_si;
    logic                r_step;
    logic                r_core_rst;
    logic                r_in_ready;
    logic                r_lut_done;
    logic                r_frame_done;

    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [7:0]          w_head;
    logic                w_empty;
    logic                w_full_next;

    // The restart-cycle handshake is void even though in_ready may still read 1.
    assign w_push  = in_valid && r_in_ready && !restart;
    assign w_issue = (r_state == STREAM) && !w_empty;
    assign w_pop   = w_issue && r_phase;

    s4ga_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (restart),
        .i_push      (w_push),
        .i_data      (in_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full_next (w_full_next)
    );

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_state      <= RST_SEQ;
            r_rst_cnt    <= '0;
            r_phase      <= 1'b0;
            r_seg_cnt    <= '0;
            r_lut_cnt    <= '0;
            r_si         <= '0;
            r_step       <= 1'b0;
            r_core_rst   <= 1'b1;
            r_in_ready   <= 1'b0;
            r_lut_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_lut_done   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                RST_SEQ: begin
                    r_step     <= 1'b1;
                    r_core_rst <= 1'b1;
                    r_si       <= '0;
                    r_in_ready <= 1'b0;
                    r_rst_cnt  <= r_rst_cnt + c_RST_ONE;
                    if (r_rst_cnt == c_RST_LAST) r_state <= STREAM;
                end
                STREAM: begin
                    r_core_rst <= 1'b0;
                    r_in_ready <= !w_full_next;
                    r_step     <= w_issue;
                    if (w_issue) begin
                        r_si    <= r_phase ? w_head[3:0] : w_head[7:4];
                        r_phase <= !r_phase;
                        // Boundary flags mirror the core's own segment/LUT counters.
                        if (r_seg_cnt == c_SEG_LAST) begin
                            r_seg_cnt  <= '0;
                            r_lut_done <= 1'b1;
                            if (r_lut_cnt == c_LUT_LAST) begin
                                r_lut_cnt    <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_lut_cnt <= r_lut_cnt + c_LUT_ONE;
                            end
                        end else begin
                            r_seg_cnt <= r_seg_cnt + c_SEG_ONE;
                        end
                    end
                end
                default: r_state <= RST_SEQ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign si         = r_si;
    assign step       = r_step;
    assign core_rst   = r_core_rst;
    assign lut_done   = r_lut_done;
    assign frame_done = r_frame_done;

`ifdef S4GA_CFG_STATS_EN
    logic [15:0] r_underrun;

    // Counts cycles the core is left waiting in the middle of a LUT record.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_underrun <= '0;
        end else if ((r_state == STREAM) && !w_issue && (r_seg_cnt != '0)
                     && (r_underrun != 16'hFFFF)) begin
            r_underrun <= r_underrun + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun;
`else
    assign underrun_cnt = '0;
`endif

endmodule
`default_nettype wire
